// File: rtl/ram_arbiter.sv
// Two-master arbiter serialising AXI-lite-style writes and reads onto one single-port RAM slave.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN to make M0 always win contention.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1 (data)
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // slave (RAM)
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [31:0]       s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready
);

  typedef enum logic [2:0] {StIdle, StWAddr, StWResp, StRAddr, StRResp} state_e;

  state_e     state_q;
  logic       gnt_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic       last_q;
`endif
  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic [1:0] any_req;
  logic       sel;

  assign wr_req  = {m1_awvalid && m1_wvalid, m0_awvalid && m0_wvalid};
  assign rd_req  = {m1_arvalid, m0_arvalid};
  assign any_req = wr_req | rd_req;

  always_comb begin
    sel = any_req[1];
    if (any_req == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = !last_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (|any_req) begin
            gnt_q   <= sel;
            // A master with both ops pending has its write served first.
            state_q <= wr_req[sel] ? StWAddr : StRAddr;
          end
        end
        StWAddr: if (s_awvalid && s_wvalid && s_awready) state_q <= StWResp;
        StWResp: begin
          if (s_bvalid && s_bready) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q  <= gnt_q;
`endif
            state_q <= StIdle;
          end
        end
        StRAddr: if (s_arvalid && s_arready) state_q <= StRResp;
        StRResp: begin
          if (s_rvalid && s_rready) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q  <= gnt_q;
`endif
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic in_waddr, in_wresp, in_raddr, in_rresp, w_acc;

  assign in_waddr = (state_q == StWAddr);
  assign in_wresp = (state_q == StWResp);
  assign in_raddr = (state_q == StRAddr);
  assign in_rresp = (state_q == StRResp);

  assign s_awaddr  = gnt_q ? m1_awaddr : m0_awaddr;
  assign s_wdata   = gnt_q ? m1_wdata  : m0_wdata;
  assign s_wstrb   = gnt_q ? m1_wstrb  : m0_wstrb;
  assign s_araddr  = gnt_q ? m1_araddr : m0_araddr;
  assign s_awvalid = in_waddr && (gnt_q ? m1_awvalid : m0_awvalid);
  assign s_wvalid  = in_waddr && (gnt_q ? m1_wvalid  : m0_wvalid);
  assign s_bready  = in_wresp && (gnt_q ? m1_bready  : m0_bready);
  assign s_arvalid = in_raddr && (gnt_q ? m1_arvalid : m0_arvalid);
  assign s_rready  = in_rresp && (gnt_q ? m1_rready  : m0_rready);

  // Address and data are accepted together so the master never sees a split handshake.
  assign w_acc = in_waddr && s_awready && s_wready;

  assign m0_awready = w_acc && !gnt_q;
  assign m0_wready  = w_acc && !gnt_q;
  assign m0_bvalid  = in_wresp && s_bvalid && !gnt_q;
  assign m0_arready = in_raddr && s_arready && !gnt_q;
  assign m0_rvalid  = in_rresp && s_rvalid && !gnt_q;
  assign m0_rdata   = s_rdata;

  assign m1_awready = w_acc && gnt_q;
  assign m1_wready  = w_acc && gnt_q;
  assign m1_bvalid  = in_wresp && s_bvalid && gnt_q;
  assign m1_arready = in_raddr && s_arready && gnt_q;
  assign m1_rvalid  = in_rresp && s_rvalid && gnt_q;
  assign m1_rdata   = s_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural zero-wait RAM slave plus read-data scoreboard.
module tb_ram_arbiter;

  localparam int Bound = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [31:0] araddr [2];
  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
  logic [1:0]  awready, wready, bvalid, arready, rvalid;
  logic [31:0] m0_rdata, m1_rdata;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

  logic [14:0] all_hs;
  assign all_hs = {awready, wready, bvalid, arready, rvalid,
                   s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready};

  ram_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
    .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
    .m0_rdata(m0_rdata), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
    .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
    .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
    .m1_rdata(m1_rdata), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  // Zero-wait single-port RAM, response registered one cycle after acceptance.
  logic [31:0] mem [64];
  assign s_awready = 1'b1;
  assign s_wready  = 1'b1;
  assign s_arready = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else begin
      if (s_awvalid && s_wvalid) begin
        for (int i = 0; i < 4; i++) begin
          if (s_wstrb[i]) mem[s_awaddr[7:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        end
        s_bvalid <= 1'b1;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (s_arvalid) begin
        s_rdata  <= mem[s_araddr[7:2]];
        s_rvalid <= 1'b1;
      end else if (s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  logic [31:0] shadow [64];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          grant_log [$];
  int          exp_order [6];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input int m);
    return (m != 0) ? m1_rdata : m0_rdata;
  endfunction

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int bdelay,
                          output int lat_aw, output int lat_b);
    int t;
    int o;
    o = 1 - m;
    shadow[a[7:2]] = merge(shadow[a[7:2]], d, s);
    awaddr[m] = a; wdata[m] = d; wstrb[m] = s; awvalid[m] = 1'b1; wvalid[m] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready[m] && t < Bound);
    lat_aw = t;
    lat_b  = t;
    if (!awready[m]) begin
      check("aw_timeout", {31'h0, awready[m]}, 32'h1);
      awvalid[m] = 1'b0; wvalid[m] = 1'b0;
      return;
    end
    grant_log.push_back(2 * m);
    check("wready_with_awready", {31'h0, wready[m]}, 32'h1);
    check("other_ready_low_w", {29'h0, awready[o], wready[o], arready[o]}, 32'h0);
    @(negedge clk); t++;
    awvalid[m] = 1'b0; wvalid[m] = 1'b0;
    while (!bvalid[m] && t < Bound) begin @(negedge clk); t++; end
    lat_b = t;
    if (!bvalid[m]) begin
      check("b_timeout", {31'h0, bvalid[m]}, 32'h1);
      return;
    end
    check("other_bvalid_low", {31'h0, bvalid[o]}, 32'h0);
    repeat (bdelay) begin
      @(negedge clk);
      check("b_hold", {31'h0, bvalid[m]}, 32'h1);
    end
    bready[m] = 1'b1;
    @(negedge clk);
    bready[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [31:0] a, input int rdelay,
                         output int lat_ar, output int lat_r);
    int t;
    int o;
    logic [31:0] exp;
    o = 1 - m;
    exp = shadow[a[7:2]];
    if (m != 0) exp_q1.push_back(exp);
    else exp_q0.push_back(exp);
    araddr[m] = a; arvalid[m] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready[m] && t < Bound);
    lat_ar = t;
    lat_r  = t;
    if (!arready[m]) begin
      check("ar_timeout", {31'h0, arready[m]}, 32'h1);
      arvalid[m] = 1'b0;
      return;
    end
    grant_log.push_back(2 * m + 1);
    check("other_ready_low_r", {29'h0, awready[o], wready[o], arready[o]}, 32'h0);
    @(negedge clk); t++;
    arvalid[m] = 1'b0;
    while (!rvalid[m] && t < Bound) begin @(negedge clk); t++; end
    lat_r = t;
    if (!rvalid[m]) begin
      check("r_timeout", {31'h0, rvalid[m]}, 32'h1);
      return;
    end
    check("other_rvalid_low", {31'h0, rvalid[o]}, 32'h0);
    check("rdata_fanout", rd(o), exp);
    repeat (rdelay) begin
      @(negedge clk);
      check("bp_rvalid_held", {31'h0, rvalid[m]}, 32'h1);
      check("bp_rdata_held", rd(m), exp);
      check("bp_other_blocked", {29'h0, awready[o], wready[o], arready[o]}, 32'h0);
    end
    rready[m] = 1'b1;
    if (m != 0) check("m1_rdata", rd(m), exp_q1.pop_front());
    else check("m0_rdata", rd(m), exp_q0.pop_front());
    @(negedge clk);
    rready[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la0, lb0, la1, lr1, lr0;
    for (int i = 0; i < 64; i++) begin
      mem[i] <= 32'hA500_0000 | i;
      shadow[i] = 32'hA500_0000 | i;
    end
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = 32'h0; wdata[m] = 32'h0; wstrb[m] = 4'h0; araddr[m] = 32'h0;
    end
    awvalid = 2'b00; wvalid = 2'b00; bready = 2'b00; arvalid = 2'b00; rready = 2'b00;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_order = '{1, 1, 1, 3, 3, 3};
`else
    exp_order = '{1, 3, 1, 3, 1, 3};
`endif

    // Reset state
    @(negedge clk);
    check("reset_hs_zero", {17'h0, all_hs}, 32'h0);
    check("reset_m0_rdata", m0_rdata, s_rdata);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hs_zero", {17'h0, all_hs}, 32'h0);

    // Contention out of reset: M0 first, then grants alternate (or M0 keeps winning)
    grant_log.delete();
    fork
      for (int k = 0; k < 3; k++) do_read(0, 32'h0, 0, la0, lr0);
      for (int k = 0; k < 3; k++) do_read(1, 32'h4, 0, la1, lr1);
    join
    check("grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check($sformatf("grant_order%0d", i), grant_log[i], exp_order[i]);
    end

    // Single write by M1, then M0 reads it back
    do_write(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, la1, lb0);
    check("m1_awready_cycle", la1, 1);
    check("m1_bvalid_cycle", lb0, 2);
    do_read(0, 32'h10, 0, la0, lr0);
    check("m0_arready_cycle", la0, 1);
    check("m0_rvalid_cycle", lr0, 2);

    // Byte write merges into the existing word
    do_write(0, 32'h20, 32'h1122_3344, 4'hF, 0, la0, lb0);
    do_write(0, 32'h20, 32'h0000_AB00, 4'h2, 2, la0, lb0);
    do_read(0, 32'h20, 0, la0, lr0);

    // Read backpressure on M1 while M0 waits
    fork
      do_read(1, 32'h10, 5, la1, lr1);
      begin @(negedge clk); do_read(0, 32'h20, 0, la0, lr0); end
    join
    check("bp_m0_wait", la0, 8);

    // Same master, write and read pending together: write first, read sees new data
    fork
      do_write(0, 32'h30, 32'hCAFE_0001, 4'hF, 0, la0, lb0);
      begin #1; do_read(0, 32'h30, 0, la1, lr1); end
    join
    check("wr_first_lat", la0, 1);
    check("rd_second_lat", la1, 4);

    // Reset pulsed in W_RESP
    shadow[16] = 32'h0123_4567;
    awaddr[1] = 32'h40; wdata[1] = 32'h0123_4567; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(negedge clk);
    check("rst_pre_awready", {31'h0, awready[1]}, 32'h1);
    @(negedge clk);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    check("rst_pre_bvalid", {31'h0, bvalid[1]}, 32'h1);
    #1 rst = 1'b1;
    #1 check("rst_async_hs_zero", {17'h0, all_hs}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_next_hs_zero", {17'h0, all_hs}, 32'h0);
    do_write(0, 32'h44, 32'h0BAD_F00D, 4'hF, 0, la0, lb0);
    check("post_rst_aw_cycle", la0, 1);
    check("post_rst_b_cycle", lb0, 2);
    do_read(1, 32'h40, 0, la1, lr1);
    do_read(1, 32'h44, 0, la1, lr1);
    check("post_rst_r_cycle", lr1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares one `simple_ram`-style single-port memory slave between an instruction-fetch master (M0) and a data master (M1). It sits between the core's OBI-to-bus adapters and the RAM. It serialises accesses: one transaction (write or read) is outstanding at a time. Master selection is round-robin by default, with fixed priority selectable at compile time.

## Interface
Parameters:
- `ADDR_W`, 32, address width passed through to the slave.

Ports (N = 0, 1; every master port exists once per master):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mN_awaddr`  in  ADDR_W  write address.
- `mN_awvalid`, `mN_wvalid`  in  1 each  write address valid, write data valid.
- `mN_awready`, `mN_wready`  out  1 each  write address ready, write data ready.
- `mN_wdata`  in  32  write data.
- `mN_wstrb`  in  4  write byte strobes.
- `mN_bvalid`  out  1  write response valid.
- `mN_bready`  in  1  write response ready.
- `mN_araddr`  in  ADDR_W  read address.
- `mN_arvalid`  in  1  read address valid.
- `mN_arready`  out  1  read address ready.
- `mN_rdata`  out  32  read data.
- `mN_rvalid`  out  1  read data valid.
- `mN_rready`  in  1  read data ready.
- `s_*`  mirror set toward the RAM, same names and widths with directions inverted: `s_awaddr`, `s_awvalid`, `s_awready`, `s_wdata`, `s_wstrb`, `s_wvalid`, `s_wready`, `s_bvalid`, `s_bready`, `s_araddr`, `s_arvalid`, `s_arready`, `s_rdata`, `s_rvalid`, `s_rready`.

## Operation
- Request definitions:
  - Write request of master N: `mN_awvalid && mN_wvalid`.
  - Read request of master N: `mN_arvalid`.
  - If one master has both pending, its write is served first.
- FSM states: IDLE, W_ADDR, W_RESP, R_ADDR, R_RESP. `gnt` (1 bit) and `last` (1 bit) are registered.
- IDLE:
  - If any request is pending, select the master, register it in `gnt`, and go to W_ADDR or R_ADDR according to that master's op.
  - All slave valids are 0 in IDLE.
- Round-robin rule: if both masters request, grant `!last`. If only one requests, grant that one.
- W_ADDR:
  - `s_aw*` and `s_w*` are driven from master `gnt`.
  - `mgnt_awready = mgnt_wready = s_awready && s_wready`.
  - On `s_awvalid && s_wvalid && s_awready`, go to W_RESP.
- W_RESP:
  - `mgnt_bvalid = s_bvalid` and `s_bready = mgnt_bready`.
  - On `s_bvalid && s_bready`, set `last <= gnt` and go to IDLE.
- R_ADDR / R_RESP follow the same pattern on the AR and R channels.
  - `s_rdata` fans out to both `mN_rdata`; only `mgnt_rvalid` is asserted.
- Non-granted master sees all readies and response valids at 0.
- Addresses, data and strobes pass through unmodified. There is no decode and no width conversion.
- If a master drops valid in W_ADDR/R_ADDR (a protocol violation), the FSM stays in that state until the slave accepts.

## Timing
- Reset values:
  - FSM = IDLE, `gnt` = 0, `last` = 1 (so M0 wins the first contention).
  - All `mN_*ready`, `mN_bvalid`, `mN_rvalid`, `s_*valid`, `s_bready`, `s_rready` = 0.
  - `mN_rdata` follows `s_rdata`.
- Write, with the RAM's zero-wait `awready`:
  - Request seen in cycle 0 (IDLE).
  - W_ADDR in cycle 1: RAM accepts, master handshake completes.
  - `mN_bvalid` in cycle 2.
  - Back in IDLE in cycle 3 if `bready` is high.
- Read: same cycle structure; `mN_rvalid` and valid `rdata` appear in cycle 2.
- Minimum spacing is 3 cycles per transaction. Throughput is 1 transaction per 3 cycles when responses are accepted immediately.
- Response backpressure (`bready`/`rready` low) holds W_RESP/R_RESP indefinitely. No other master is served meanwhile.
- Asserting `rst` in any state aborts to IDLE asynchronously. The RAM shares the system reset, so no response is left pending.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: M0 always wins contention; the `last` register is not used.
  - Undefined (default): round-robin as described above.

## Test plan
- Single write, M1 `awaddr=0x10`, `wdata=0xDEADBEEF`, `wstrb=0xF` -> `m1_awready` in cycle 1, `m1_bvalid` in cycle 2; a later M0 read of 0x10 returns 0xDEADBEEF with `m0_rvalid` in cycle 2.
- Simultaneous M0 read of 0x0 and M1 read of 0x4 out of reset -> M0 served first, then M1. Each `rvalid` is seen only by its own master. Default build alternates grants on repeated contention; with `RAM_ARB_FIXED_PRIO_EN`, M0 wins every time.
- Byte write: M0 `wstrb=0x2`, `wdata=0x0000AB00` to a word holding 0x11223344 -> read returns 0x1122AB44.
- Backpressure: M1 `rready` held low for 5 cycles -> `m1_rvalid` and `rdata` held stable. M0's pending request gets no ready until M1 completes.
- Same master with write and read pending in one cycle -> write granted first, read next, and the read returns the new data.
- `rst` pulsed in W_RESP -> FSM returns to IDLE, all valid/ready outputs are 0 in the next cycle, and a following transaction completes normally.
